// File: rtl/prox_pkg.sv
// Shared definitions for the proximity sensor debounce/event stage.
//   prox_state_t           : debounce FSM state encoding
//   PROX_CNT_W             : width of the consecutive-sample run counter
//   PROX_DEBOUNCE_DEFAULT  : default run length needed to change state
package prox_pkg;

  localparam int unsigned PROX_CNT_W            = 8;
  localparam int unsigned PROX_DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    ABSENT,
    ARMING,
    PRESENT,
    RELEASING
  } prox_state_t;

endpackage

// File: rtl/proximity_filter_if.sv
// Signal bundle between the sensor sampler side and proximity_filter.
//   sensor_en     : enable driving the upstream sampler
//   sample_in     : registered sensor value, X/Z while disabled
//   count_clr     : synchronous clear of det_count
//   present       : filtered presence
//   detect_pulse  : one-cycle pulse on confirmed absent->present
//   release_pulse : one-cycle pulse on confirmed present->absent
//   det_count     : saturating detect event count
//   count_sat     : high while det_count is all ones
// master drives the inputs of the filter; slave is the filter itself.
interface proximity_filter_if #(
  parameter int unsigned COUNT_W = 8
) ();

  logic               sensor_en;
  logic               sample_in;
  logic               count_clr;
  logic               present;
  logic               detect_pulse;
  logic               release_pulse;
  logic [COUNT_W-1:0] det_count;
  logic               count_sat;

  modport master (
    output sensor_en,
    output sample_in,
    output count_clr,
    input  present,
    input  detect_pulse,
    input  release_pulse,
    input  det_count,
    input  count_sat
  );

  modport slave (
    input  sensor_en,
    input  sample_in,
    input  count_clr,
    output present,
    output detect_pulse,
    output release_pulse,
    output det_count,
    output count_sat
  );

endinterface

// File: rtl/prox_event_counter.sv
// Saturating event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event
//   clr        : synchronous clear; clr with inc in the same cycle loads 1
//   count      : registered count, holds at all ones
//   sat        : registered, high while count is all ones
module prox_event_counter #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               sat
);

  localparam logic [COUNT_W-1:0] CountMax = {COUNT_W{1'b1}};

  logic [COUNT_W-1:0] count_q, count_d;
  logic               sat_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? COUNT_W'(1) : '0;
    end else if (inc && (count_q != CountMax)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      // Derived from the next value so sat rises on the same edge as the max count.
      sat_q   <= (count_d == CountMax);
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/proximity_filter.sv
// Debounce and event stage downstream of the proximity sensor sampler.
// Confirms presence/absence after DEBOUNCE_CYCLES consecutive qualified samples and emits
// one-cycle detect/release pulses. Samples are qualified by the sampler enable delayed one
// cycle (en_q), so samples taken while the sensor is disabled are never decoded.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : proximity_filter_if slave (sensor_en, sample_in, count_clr in;
//                present, detect_pulse, release_pulse, det_count, count_sat out)
// Build option PROX_FILTER_COUNT_EN: when defined the saturating detect counter is built;
// otherwise det_count and count_sat are tied to 0 and count_clr is ignored.
module proximity_filter
  import prox_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = PROX_DEBOUNCE_DEFAULT,
  parameter int unsigned COUNT_W         = 8
) (
  input logic               clk,
  input logic               rst_n,
  proximity_filter_if.slave bus
);

  localparam logic [PROX_CNT_W-1:0] DebTarget = PROX_CNT_W'(DEBOUNCE_CYCLES);

  prox_state_t           state_q, state_d;
  logic [PROX_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                  en_q;
  logic                  present_q, detect_q, release_q;
  logic                  detect_d, release_d;

  assign cnt_inc = cnt_q + PROX_CNT_W'(1);

  // State and cnt only move on qualified samples; a disable gap freezes the run.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    detect_d  = 1'b0;
    release_d = 1'b0;
    if (en_q) begin
      unique case (state_q)
        ABSENT: begin
          if (bus.sample_in) begin
            state_d = ARMING;
            cnt_d   = PROX_CNT_W'(1);
          end
        end
        ARMING: begin
          if (bus.sample_in) begin
            if (cnt_inc == DebTarget) begin
              state_d  = PRESENT;
              cnt_d    = '0;
              detect_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ABSENT;
            cnt_d   = '0;
          end
        end
        PRESENT: begin
          if (!bus.sample_in) begin
            state_d = RELEASING;
            cnt_d   = PROX_CNT_W'(1);
          end
        end
        RELEASING: begin
          if (!bus.sample_in) begin
            if (cnt_inc == DebTarget) begin
              state_d   = ABSENT;
              cnt_d     = '0;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = PRESENT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ABSENT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ABSENT;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      present_q <= 1'b0;
      detect_q  <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_q      <= bus.sensor_en;
      present_q <= (state_d == PRESENT) || (state_d == RELEASING);
      detect_q  <= detect_d;
      release_q <= release_d;
    end
  end

  assign bus.present       = present_q;
  assign bus.detect_pulse  = detect_q;
  assign bus.release_pulse = release_q;

  logic [COUNT_W-1:0] det_count;
  logic               count_sat;

`ifdef PROX_FILTER_COUNT_EN
  // Driven from detect_d so det_count updates on the same edge detect_pulse rises.
  prox_event_counter #(
    .COUNT_W(COUNT_W)
  ) u_event_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (detect_d),
    .clr  (bus.count_clr),
    .count(det_count),
    .sat  (count_sat)
  );
`else
  logic unused_count_clr;
  assign unused_count_clr = bus.count_clr;
  assign det_count        = '0;
  assign count_sat        = 1'b0;
`endif

  assign bus.det_count = det_count;
  assign bus.count_sat = count_sat;

endmodule

// File: tb/tb_proximity_filter.sv
// Directed self-checking bench for proximity_filter. Instance a uses COUNT_W=8, instance b
// uses COUNT_W=2 for saturation. Each tick drives inputs on the falling edge and checks
// outputs 1 time unit after the rising edge. sample_in is driven already aligned with the
// DUT's internal en_q (i.e. as the sampler would present it).
module tb_proximity_filter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  proximity_filter_if #(.COUNT_W(8)) bus_a ();
  proximity_filter_if #(.COUNT_W(2)) bus_b ();

  proximity_filter #(
    .DEBOUNCE_CYCLES(4),
    .COUNT_W        (8)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a.slave)
  );

  proximity_filter #(
    .DEBOUNCE_CYCLES(4),
    .COUNT_W        (2)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected detect counts depend on whether the counter is built.
  function automatic logic [7:0] ec8(input int n);
`ifdef PROX_FILTER_COUNT_EN
    return 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  function automatic logic [1:0] ec2(input int n);
`ifdef PROX_FILTER_COUNT_EN
    return 2'(n);
`else
    return 2'd0;
`endif
  endfunction

  function automatic logic esat(input logic s);
`ifdef PROX_FILTER_COUNT_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick(input logic en, input logic s, input logic clr);
    @(negedge clk);
    bus_a.sensor_en = en;
    bus_a.sample_in = s;
    bus_a.count_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b(input logic en, input logic s, input logic clr);
    @(negedge clk);
    bus_b.sensor_en = en;
    bus_b.sample_in = s;
    bus_b.count_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.sensor_en = 1'b0;
    bus_a.sample_in = 1'b0;
    bus_a.count_clr = 1'b0;
    bus_b.sensor_en = 1'b0;
    bus_b.sample_in = 1'b0;
    bus_b.count_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_a.present, bus_a.detect_pulse, bus_a.release_pulse} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 000",
               {bus_a.present, bus_a.detect_pulse, bus_a.release_pulse});
    end
    n_checks++;
    if ({bus_a.det_count, bus_a.count_sat} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %h/%b want 00/0", bus_a.det_count, bus_a.count_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_detect();
    tick(1'b1, 1'bz, 1'b0);
    n_checks++;
    if (bus_a.present !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_present: got %b want 0", bus_a.present);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({bus_a.present, bus_a.detect_pulse, bus_a.release_pulse} !==
          {(i >= 3), (i == 3), 1'b0}) begin
        n_fail++;
        $display("FAIL detect step %0d: got pdr=%b want %b", i,
                 {bus_a.present, bus_a.detect_pulse, bus_a.release_pulse},
                 {(i >= 3), (i == 3), 1'b0});
      end
    end
    n_checks++;
    if (bus_a.det_count !== ec8(1)) begin
      n_fail++;
      $display("FAIL detect_count: got %0d want %0d", bus_a.det_count, ec8(1));
    end
  endtask

  task automatic test_release();
    bit pat [16];
    bit ep  [16];
    bit ed  [16];
    bit er  [16];
    pat = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    ep  = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    ed  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    er  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, pat[i], 1'b0);
      n_checks++;
      if ({bus_a.present, bus_a.detect_pulse, bus_a.release_pulse} !==
          {ep[i], ed[i], er[i]}) begin
        n_fail++;
        $display("FAIL release step %0d: got pdr=%b want %b", i,
                 {bus_a.present, bus_a.detect_pulse, bus_a.release_pulse},
                 {ep[i], ed[i], er[i]});
      end
    end
    n_checks++;
    if (bus_a.det_count !== ec8(2)) begin
      n_fail++;
      $display("FAIL release_count: got %0d want %0d", bus_a.det_count, ec8(2));
    end
  endtask

  task automatic test_glitch();
    bit pat [11];
    bit ep  [11];
    bit ed  [11];
    bit er  [11];
    pat = '{1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    ep  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    ed  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    er  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 11; i++) begin
      tick(1'b1, pat[i], 1'b0);
      n_checks++;
      if ({bus_a.present, bus_a.detect_pulse, bus_a.release_pulse} !==
          {ep[i], ed[i], er[i]}) begin
        n_fail++;
        $display("FAIL glitch step %0d: got pdr=%b want %b", i,
                 {bus_a.present, bus_a.detect_pulse, bus_a.release_pulse},
                 {ep[i], ed[i], er[i]});
      end
    end
    n_checks++;
    if (bus_a.det_count !== ec8(3)) begin
      n_fail++;
      $display("FAIL glitch_count: got %0d want %0d", bus_a.det_count, ec8(3));
    end
  endtask

  task automatic test_gap();
    logic en  [13];
    logic s   [13];
    bit   ep  [13];
    bit   ed  [13];
    bit   er  [13];
    en = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    s  = '{1, 1, 1'bz, 1'bz, 1'bz, 1'bz, 1'bz, 1, 1, 0, 0, 0, 0};
    ep = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    ed = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    er = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 13; i++) begin
      tick(en[i], s[i], 1'b0);
      n_checks++;
      if ({bus_a.present, bus_a.detect_pulse, bus_a.release_pulse} !==
          {ep[i], ed[i], er[i]}) begin
        n_fail++;
        $display("FAIL gap step %0d: got pdr=%b want %b", i,
                 {bus_a.present, bus_a.detect_pulse, bus_a.release_pulse},
                 {ep[i], ed[i], er[i]});
      end
    end
    n_checks++;
    if (bus_a.det_count !== ec8(4)) begin
      n_fail++;
      $display("FAIL gap_count: got %0d want %0d", bus_a.det_count, ec8(4));
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (bus_a.present !== 1'b0) begin
      n_fail++;
      $display("FAIL arming_present: got %b want 0", bus_a.present);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.present, bus_a.detect_pulse, bus_a.release_pulse, bus_a.det_count,
         bus_a.count_sat} !== 12'd0) begin
      n_fail++;
      $display("FAIL async_reset: got p=%b d=%b r=%b cnt=%0d sat=%b want all 0",
               bus_a.present, bus_a.detect_pulse, bus_a.release_pulse, bus_a.det_count,
               bus_a.count_sat);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'bz, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({bus_a.present, bus_a.detect_pulse} !== {(i == 3), (i == 3)}) begin
        n_fail++;
        $display("FAIL rerun step %0d: got pd=%b want %b", i,
                 {bus_a.present, bus_a.detect_pulse}, {(i == 3), (i == 3)});
      end
    end
    n_checks++;
    if (bus_a.det_count !== ec8(1)) begin
      n_fail++;
      $display("FAIL rerun_count: got %0d want %0d", bus_a.det_count, ec8(1));
    end
  endtask

  task automatic test_count_clr();
    // In PRESENT with one detect counted: a plain clear empties the counter.
    tick(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (bus_a.det_count !== ec8(0)) begin
      n_fail++;
      $display("FAIL clr_only: got %0d want 0", bus_a.det_count);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({bus_a.detect_pulse, bus_a.det_count, bus_a.count_sat} !== {1'b1, ec8(1), 1'b0}) begin
      n_fail++;
      $display("FAIL clr_with_detect: got d=%b cnt=%0d sat=%b want d=1 cnt=%0d sat=0",
               bus_a.detect_pulse, bus_a.det_count, bus_a.count_sat, ec8(1));
    end
  endtask

  task automatic test_saturation();
    tick_b(1'b1, 1'bz, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < 4; i++) tick_b(1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({bus_b.detect_pulse, bus_b.det_count, bus_b.count_sat} !==
          {1'b1, ec2((k > 3) ? 3 : k), esat(k >= 3)}) begin
        n_fail++;
        $display("FAIL sat detect %0d: got d=%b cnt=%0d sat=%b want d=1 cnt=%0d sat=%b", k,
                 bus_b.detect_pulse, bus_b.det_count, bus_b.count_sat,
                 ec2((k > 3) ? 3 : k), esat(k >= 3));
      end
      for (int i = 0; i < 4; i++) tick_b(1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick_b(1'b1, 1'b1, 1'b0);
    tick_b(1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({bus_b.detect_pulse, bus_b.det_count, bus_b.count_sat} !== {1'b1, ec2(1), 1'b0}) begin
      n_fail++;
      $display("FAIL sat_clr_with_detect: got d=%b cnt=%0d sat=%b want d=1 cnt=%0d sat=0",
               bus_b.detect_pulse, bus_b.det_count, bus_b.count_sat, ec2(1));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_detect();
    test_release();
    test_glitch();
    test_gap();
    test_reset_mid_run();
    test_count_clr();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
